// File: rtl/rx_frame_buffer_ctrl_if.sv
// Receive-side and consumer-side signal bundle for rx_frame_buffer_ctrl.
// The slave modport is the buffer's view; master is the driver/consumer view.
interface rx_frame_buffer_ctrl_if #(
  parameter int LEN_W = 11
);
  logic             rx_receive;
  logic             rx_byte_toggle;
  logic [7:0]       rx_data;
  logic             rx_crc_ok;
  logic             frame_avail;
  logic [LEN_W-1:0] frame_len;
  logic             rd_en;
  logic [7:0]       rd_data;
  logic             rd_valid;
  logic             rd_last;
  logic [15:0]      frames_ok;
  logic [15:0]      frames_drop;

  modport slave (
    input  rx_receive, rx_byte_toggle, rx_data, rx_crc_ok, rd_en,
    output frame_avail, frame_len, rd_data, rd_valid, rd_last, frames_ok, frames_drop
  );

  modport master (
    output rx_receive, rx_byte_toggle, rx_data, rx_crc_ok, rd_en,
    input  frame_avail, frame_len, rd_data, rd_valid, rd_last, frames_ok, frames_drop
  );
endinterface

// File: rtl/rx_frame_buffer_ctrl.sv
// RX frame buffer: writes received bytes into a circular RAM, commits or
// rolls back whole frames at end of frame, queues committed lengths in a
// descriptor FIFO and lets the consumer drain frames byte by byte.
module rx_frame_buffer_ctrl #(
  parameter int ADDR_W     = 11,
  parameter int DESC_DEPTH = 4,
  parameter int LEN_W      = 11,
  parameter int MIN_LEN    = 1,
  parameter int MAX_LEN    = 1518
) (
  input  logic                  clk,
  input  logic                  reset,
  rx_frame_buffer_ctrl_if.slave bus
);
  localparam int DEPTH = 2**ADDR_W;
  localparam int DP_W  = $clog2(DESC_DEPTH);
  localparam logic [LEN_W-1:0] MIN_L   = LEN_W'(MIN_LEN);
  localparam logic [LEN_W-1:0] MAX_L   = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);
  localparam logic [ADDR_W:0]  PTR_ONE = (ADDR_W+1)'(1);
  localparam logic [DP_W:0]    DCNT_FULL = (DP_W+1)'(DESC_DEPTH);

  typedef enum logic [1:0] {W_IDLE, W_SFD, W_DATA, W_EOF} wstate_e;

  wstate_e          state_q, state_d;
  logic             rcv_q, tog_q, crc_q;
  logic [ADDR_W:0]  wr_ptr_q, wr_ptr_d, commit_ptr_q, commit_ptr_d, rd_ptr_q;
  logic [LEN_W-1:0] frame_cnt_q, frame_cnt_d, rd_cnt_q;
  logic             err_q, err_d;
  logic             ram_we, push, drop, pop, accept;
  logic [15:0]      ok_q, drop_q;
  logic [7:0]       rd_data_q;
  logic             rd_valid_q, rd_last_q;

  logic [7:0]       ram [DEPTH];
  logic [LEN_W-1:0] desc_mem [DESC_DEPTH];
  logic [DP_W-1:0]  desc_wp_q, desc_rp_q;
  logic [DP_W:0]    desc_cnt_q;

  logic             strobe, rise, eof, ram_full, desc_full, avail;
  logic [ADDR_W:0]  used;
  logic [LEN_W-1:0] head_len;

  assign strobe    = bus.rx_byte_toggle != tog_q;
  assign rise      = bus.rx_receive & ~rcv_q;
  assign eof       = ~bus.rx_receive & rcv_q;
  // Occupancy includes uncommitted bytes, so a growing frame cannot overwrite unread data.
  assign used      = wr_ptr_q - rd_ptr_q;
  assign ram_full  = used[ADDR_W];
  assign desc_full = desc_cnt_q == DCNT_FULL;
  assign avail     = desc_cnt_q != '0;
  assign head_len  = desc_mem[desc_rp_q];
  assign accept    = bus.rd_en & avail;
  assign pop       = accept & (LEN_W'(rd_cnt_q + LEN_ONE) == head_len);

  assign bus.frame_avail = avail;
  assign bus.frame_len   = avail ? head_len : '0;
  assign bus.rd_data     = rd_data_q;
  assign bus.rd_valid    = rd_valid_q;
  assign bus.rd_last     = rd_last_q;
  assign bus.frames_ok   = ok_q;
  assign bus.frames_drop = drop_q;

  // Write FSM next state: byte store, overflow flagging and commit/rollback decision.
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    commit_ptr_d = commit_ptr_q;
    frame_cnt_d  = frame_cnt_q;
    err_d        = err_q;
    ram_we       = 1'b0;
    push         = 1'b0;
    drop         = 1'b0;
    case (state_q)
      W_IDLE: if (rise) begin
        state_d     = W_SFD;
        frame_cnt_d = '0;
        err_d       = 1'b0;
      end
      W_SFD: begin
        // The first strobe is the SFD; an EOF here aborts silently.
        if (eof)         state_d = W_IDLE;
        else if (strobe) state_d = W_DATA;
      end
      W_DATA: begin
        if (strobe) begin
          if (!ram_full && frame_cnt_q < MAX_L) begin
            ram_we      = 1'b1;
            wr_ptr_d    = wr_ptr_q + PTR_ONE;
            frame_cnt_d = frame_cnt_q + LEN_ONE;
          end else begin
            err_d = 1'b1;
          end
        end
        if (eof) state_d = W_EOF;
      end
      W_EOF: begin
        if (crc_q && !err_q && frame_cnt_q >= MIN_L && !desc_full) begin
          push         = 1'b1;
          commit_ptr_d = wr_ptr_q;
        end else begin
          drop     = 1'b1;
          wr_ptr_d = commit_ptr_q;
        end
        state_d = W_IDLE;
      end
      default: state_d = W_IDLE;
    endcase
  end

  // Write-side state, edge-detect history and saturating frame counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= W_IDLE;
      rcv_q        <= 1'b0;
      tog_q        <= 1'b0;
      crc_q        <= 1'b0;
      wr_ptr_q     <= '0;
      commit_ptr_q <= '0;
      frame_cnt_q  <= '0;
      err_q        <= 1'b0;
      ok_q         <= '0;
      drop_q       <= '0;
    end else begin
      state_q      <= state_d;
      rcv_q        <= bus.rx_receive;
      tog_q        <= bus.rx_byte_toggle;
      if (eof) crc_q <= bus.rx_crc_ok;
      wr_ptr_q     <= wr_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      frame_cnt_q  <= frame_cnt_d;
      err_q        <= err_d;
      if (push && ok_q != 16'hFFFF)   ok_q   <= ok_q + 16'd1;
      if (drop && drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
    end
  end

  // Byte RAM write port; contents are meaningless until written.
  always_ff @(posedge clk) begin
    if (ram_we) ram[wr_ptr_q[ADDR_W-1:0]] <= bus.rx_data;
  end

  // Descriptor FIFO of committed frame lengths; push and pop may coincide.
  always_ff @(posedge clk) begin
    if (reset) begin
      desc_wp_q  <= '0;
      desc_rp_q  <= '0;
      desc_cnt_q <= '0;
    end else begin
      if (push) begin
        desc_mem[desc_wp_q] <= frame_cnt_q;
        desc_wp_q           <= desc_wp_q + DP_W'(1);
      end
      if (pop) desc_rp_q <= desc_rp_q + DP_W'(1);
      case ({push, pop})
        2'b10:   desc_cnt_q <= desc_cnt_q + (DP_W+1)'(1);
        2'b01:   desc_cnt_q <= desc_cnt_q - (DP_W+1)'(1);
        default: desc_cnt_q <= desc_cnt_q;
      endcase
    end
  end

  // Read side: registered RAM read, per-frame byte count, last-byte flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q   <= '0;
      rd_cnt_q   <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
    end else begin
      rd_valid_q <= accept;
      rd_last_q  <= pop;
      if (accept) begin
        rd_data_q <= ram[rd_ptr_q[ADDR_W-1:0]];
        rd_ptr_q  <= rd_ptr_q + PTR_ONE;
        rd_cnt_q  <= pop ? '0 : rd_cnt_q + LEN_ONE;
      end
    end
  end
endmodule

// File: tb/tb_rx_frame_buffer_ctrl.sv
// Directed bench for rx_frame_buffer_ctrl with a 64-byte RAM.
module tb_rx_frame_buffer_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  rx_frame_buffer_ctrl_if #(.LEN_W(11)) bus ();

  rx_frame_buffer_ctrl #(
    .ADDR_W(6), .DESC_DEPTH(4), .LEN_W(11), .MIN_LEN(1), .MAX_LEN(1518)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  task automatic byte_in(input logic [7:0] d);
    @(negedge clk);
    bus.rx_data        = d;
    bus.rx_byte_toggle = ~bus.rx_byte_toggle;
    @(negedge clk);
  endtask

  task automatic frame_start();
    @(negedge clk);
    bus.rx_receive = 1'b1;
    byte_in(8'hD5);
  endtask

  task automatic frame_end(input logic crc);
    @(negedge clk);
    bus.rx_crc_ok  = crc;
    bus.rx_receive = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic send_frame(input int n, input logic [7:0] base, input logic crc);
    frame_start();
    for (int i = 0; i < n; i++) byte_in(8'(base + i));
    frame_end(crc);
  endtask

  task automatic read_bytes(input int n, input int from, input int to, input logic [7:0] base);
    for (int i = from; i <= to; i++) begin
      @(negedge clk);
      bus.rd_en = 1'b1;
      @(negedge clk);
      bus.rd_en = 1'b0;
      chk("rd_valid", 32'(bus.rd_valid), 32'd1);
      chk("rd_data", 32'(bus.rd_data), 32'(8'(base + i)));
      chk("rd_last", 32'(bus.rd_last), 32'(i == n - 1));
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_avail"}, 32'(bus.frame_avail), 32'd0);
    chk({tag, "_len"},   32'(bus.frame_len),   32'd0);
    chk({tag, "_valid"}, 32'(bus.rd_valid),    32'd0);
    chk({tag, "_data"},  32'(bus.rd_data),     32'd0);
    chk({tag, "_last"},  32'(bus.rd_last),     32'd0);
    chk({tag, "_ok"},    32'(bus.frames_ok),   32'd0);
    chk({tag, "_drop"},  32'(bus.frames_drop), 32'd0);
  endtask

  initial begin
    bus.rx_receive = 1'b0; bus.rx_byte_toggle = 1'b0; bus.rx_data = '0;
    bus.rx_crc_ok = 1'b0; bus.rd_en = 1'b0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    reset = 1'b0;

    // 1: good 64-byte frame fills the whole RAM, read back in order
    send_frame(64, 8'h00, 1'b1);
    chk("t1_ok", 32'(bus.frames_ok), 32'd1);
    chk("t1_drop", 32'(bus.frames_drop), 32'd0);
    chk("t1_avail", 32'(bus.frame_avail), 32'd1);
    chk("t1_len", 32'(bus.frame_len), 32'd64);
    read_bytes(64, 0, 63, 8'h00);
    chk("t1_avail_end", 32'(bus.frame_avail), 32'd0);
    @(negedge clk); bus.rd_en = 1'b1;
    @(negedge clk); bus.rd_en = 1'b0;
    chk("t1_rd_ignored", 32'(bus.rd_valid), 32'd0);

    // 2: bad CRC drops and rolls back; next frame needs the reclaimed space
    send_frame(64, 8'h80, 1'b0);
    chk("t2_drop", 32'(bus.frames_drop), 32'd1);
    chk("t2_ok", 32'(bus.frames_ok), 32'd1);
    chk("t2_avail", 32'(bus.frame_avail), 32'd0);
    send_frame(16, 8'h40, 1'b1);
    chk("t2_ok2", 32'(bus.frames_ok), 32'd2);
    chk("t2_len", 32'(bus.frame_len), 32'd16);
    read_bytes(16, 0, 15, 8'h40);

    // zero-length frame is below the minimum length
    frame_start();
    frame_end(1'b1);
    chk("min_drop", 32'(bus.frames_drop), 32'd2);
    chk("min_avail", 32'(bus.frame_avail), 32'd0);
    // EOF before SFD: no count change
    @(negedge clk); bus.rx_receive = 1'b1;
    @(negedge clk);
    @(negedge clk); bus.rx_receive = 1'b0;
    repeat (3) @(negedge clk);
    chk("sfd_abort_ok", 32'(bus.frames_ok), 32'd2);
    chk("sfd_abort_drop", 32'(bus.frames_drop), 32'd2);

    // 3: second frame overflows behind an unread one
    send_frame(40, 8'h10, 1'b1);
    send_frame(30, 8'hA0, 1'b1);
    chk("t3_ok", 32'(bus.frames_ok), 32'd3);
    chk("t3_drop", 32'(bus.frames_drop), 32'd3);
    chk("t3_len", 32'(bus.frame_len), 32'd40);
    read_bytes(40, 0, 39, 8'h10);
    chk("t3_avail_end", 32'(bus.frame_avail), 32'd0);

    // 4: descriptor FIFO full; pointers wrap across the RAM end
    for (int k = 0; k < 5; k++) send_frame(10, 8'(8'h60 + k * 10), 1'b1);
    chk("t4_ok", 32'(bus.frames_ok), 32'd7);
    chk("t4_drop", 32'(bus.frames_drop), 32'd4);
    for (int k = 0; k < 4; k++) begin
      chk("t4_len", 32'(bus.frame_len), 32'd10);
      read_bytes(10, 0, 9, 8'(8'h60 + k * 10));
    end
    chk("t4_avail_end", 32'(bus.frame_avail), 32'd0);

    // 5: last-byte pop lands on the commit cycle of the next frame
    send_frame(8, 8'hC0, 1'b1);
    read_bytes(8, 0, 6, 8'hC0);
    frame_start();
    for (int i = 0; i < 6; i++) byte_in(8'(8'hE0 + i));
    @(negedge clk); bus.rx_crc_ok = 1'b1; bus.rx_receive = 1'b0;
    @(negedge clk); bus.rd_en = 1'b1;
    @(negedge clk); bus.rd_en = 1'b0;
    chk("t5_valid", 32'(bus.rd_valid), 32'd1);
    chk("t5_data", 32'(bus.rd_data), 32'hC7);
    chk("t5_last", 32'(bus.rd_last), 32'd1);
    chk("t5_avail", 32'(bus.frame_avail), 32'd1);
    chk("t5_len", 32'(bus.frame_len), 32'd6);
    chk("t5_ok", 32'(bus.frames_ok), 32'd9);
    read_bytes(6, 0, 5, 8'hE0);
    chk("t5_avail_end", 32'(bus.frame_avail), 32'd0);

    // 6: reset during a frame and a read
    send_frame(5, 8'h01, 1'b1);
    read_bytes(5, 0, 0, 8'h01);
    frame_start();
    for (int i = 0; i < 3; i++) byte_in(8'(8'h90 + i));
    @(negedge clk);
    reset = 1'b1; bus.rx_receive = 1'b0; bus.rd_en = 1'b1;
    @(negedge clk);
    chk_zero("t6_rst");
    reset = 1'b0; bus.rd_en = 1'b0;
    send_frame(12, 8'h70, 1'b1);
    chk("t6_ok", 32'(bus.frames_ok), 32'd1);
    chk("t6_drop", 32'(bus.frames_drop), 32'd0);
    chk("t6_len", 32'(bus.frame_len), 32'd12);
    read_bytes(12, 0, 11, 8'h70);
    chk("t6_avail_end", 32'(bus.frame_avail), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
